// File: rtl/core_alu_seq.sv
// Registered ALU: one op per I_valid/O_ready handshake; latency 1, I_count for shifts, 2 for BCD adc/sbc.
// O_ready only in IDLE; O_valid and outputs hold until I_accept, requests outside IDLE are dropped.
module core_alu_seq #(
    parameter int WIDTH      = 8,
    parameter int DECIMAL    = 0,
    parameter int COUNT_BITS = 3
) (
    input  logic                  I_clock,
    input  logic                  I_reset,
    input  logic                  I_valid,
    output logic                  O_ready,
    input  logic [3:0]            I_control,
    input  logic [WIDTH-1:0]      I_lhs,
    input  logic [WIDTH-1:0]      I_rhs,
    input  logic [COUNT_BITS-1:0] I_count,
    input  logic                  I_carry,
    input  logic                  I_overflow,
    input  logic                  I_sign,
    input  logic                  I_zero,
    input  logic                  I_decimal,
    output logic                  O_valid,
    input  logic                  I_accept,
    output logic [WIDTH-1:0]      O_result,
    output logic                  O_carry,
    output logic                  O_overflow,
    output logic                  O_sign,
    output logic                  O_zero
);
    localparam int MSB = WIDTH - 1;
    localparam int NIB = WIDTH / 4;
    localparam logic [COUNT_BITS-1:0] CNT_ONE = COUNT_BITS'(1);

    localparam logic [3:0] OP_NOP = 4'd0,  OP_ADC = 4'd1,  OP_SBC = 4'd2,  OP_CMP = 4'd3;
    localparam logic [3:0] OP_INC = 4'd4,  OP_DEC = 4'd5,  OP_AND = 4'd6,  OP_BIT = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8,  OP_XOR = 4'd9,  OP_ASL = 4'd10, OP_LSR = 4'd11;
    localparam logic [3:0] OP_ROL = 4'd12, OP_ROR = 4'd13, OP_TXL = 4'd14, OP_TXR = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ADJUST, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_valid;
    logic [3:0]            r_op;
    logic [COUNT_BITS-1:0] r_cnt;
    logic [NIB-1:0]        r_nc;
    logic [WIDTH-1:0]      r_result;
    logic                  r_c, r_v, r_n, r_z;

    logic                  w_accept, w_is_shift, w_dec, w_upd;
    logic [WIDTH-1:0]      w_opnd, w_res;
    logic [WIDTH:0]        w_sum, w_diff, w_lx, w_ox;
    logic                  w_c, w_v, w_n, w_z;
    logic [NIB-1:0]        w_nc;
    logic [WIDTH-1:0]      w_st_res;
    logic                  w_st_c;
    logic [WIDTH-1:0]      w_adj_res;
    logic                  w_adj_c, w_adj_cin, w_adj_dc;
    logic [4:0]            w_adj_v;

    assign O_ready    = (r_state == S_IDLE);
    assign O_valid    = r_valid;
    assign O_result   = r_result;
    assign O_carry    = r_c;
    assign O_overflow = r_v;
    assign O_sign     = r_n;
    assign O_zero     = r_z;

    assign w_accept   = I_valid && O_ready;
    assign w_is_shift = (I_control == OP_ASL) || (I_control == OP_LSR) ||
                        (I_control == OP_ROL) || (I_control == OP_ROR);
    assign w_dec      = (DECIMAL != 0) && I_decimal &&
                        ((I_control == OP_ADC) || (I_control == OP_SBC));
    assign w_opnd     = (I_control == OP_SBC) ? ~I_rhs : I_rhs;
    assign w_sum      = {1'b0, I_lhs} + {1'b0, w_opnd} + (WIDTH+1)'(I_carry);
    assign w_diff     = {1'b0, I_lhs} + {1'b0, ~I_rhs} + (WIDTH+1)'(1);
    assign w_lx       = {1'b0, I_lhs};
    assign w_ox       = {1'b0, w_opnd};

    // Binary carry out of each nibble, kept for the BCD correction cycle.
    always_comb begin
        w_nc = '0;
        for (int i = 0; i < NIB; i++) begin
            w_nc[i] = w_sum[4*i+4] ^ w_lx[4*i+4] ^ w_ox[4*i+4];
        end
    end

    always_comb begin
        w_res = I_lhs;
        w_c   = I_carry;
        w_v   = I_overflow;
        w_n   = I_sign;
        w_z   = I_zero;
        w_upd = 1'b1;
        case (I_control)
            OP_NOP: w_upd = 1'b0;
            OP_ADC, OP_SBC: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (I_lhs[MSB] == w_opnd[MSB]) && (w_sum[MSB] != I_lhs[MSB]);
            end
            OP_CMP: begin
                w_upd = 1'b0;
                w_c   = w_diff[WIDTH];
                w_z   = (w_diff[WIDTH-1:0] == '0);
                w_n   = w_diff[MSB];
            end
            OP_INC: w_res = I_lhs + WIDTH'(1);
            OP_DEC: w_res = I_lhs - WIDTH'(1);
            OP_AND: w_res = I_lhs & I_rhs;
            OP_OR:  w_res = I_lhs | I_rhs;
            OP_XOR: w_res = I_lhs ^ I_rhs;
            OP_BIT: begin
                w_upd = 1'b0;
                w_z   = ((I_lhs & I_rhs) == '0);
                w_n   = I_rhs[MSB];
                w_v   = I_rhs[MSB-1];
            end
            OP_TXR: w_res = I_rhs;
            default: w_res = I_lhs;
        endcase
        if (w_upd) begin
            w_z = (w_res == '0);
            w_n = w_res[MSB];
        end
    end

    // One shift/rotate step; rol/ror use the carry as the extra ring bit.
    always_comb begin
        w_st_res = r_result;
        w_st_c   = r_c;
        case (r_op)
            OP_ASL:  {w_st_c, w_st_res} = {r_result, 1'b0};
            OP_LSR:  {w_st_res, w_st_c} = {1'b0, r_result};
            OP_ROL:  {w_st_c, w_st_res} = {r_result, r_c};
            OP_ROR:  {w_st_res, w_st_c} = {r_c, r_result};
            default: ;
        endcase
    end

    // adc correction ripples nibble to nibble; sbc borrows are already resolved by the binary sum.
    always_comb begin
        w_adj_res = r_result;
        w_adj_c   = r_c;
        w_adj_cin = 1'b0;
        w_adj_dc  = 1'b0;
        w_adj_v   = '0;
        for (int i = 0; i < NIB; i++) begin
            w_adj_v = {1'b0, r_result[4*i +: 4]} + {4'b0, w_adj_cin};
            if (r_op == OP_SBC) begin
                if (!r_nc[i]) w_adj_v = w_adj_v - 5'd6;
                w_adj_cin = 1'b0;
            end else begin
                w_adj_dc = r_nc[i] || (w_adj_v > 5'd9);
                if (w_adj_dc) w_adj_v = w_adj_v + 5'd6;
                w_adj_cin = w_adj_v[4];
            end
            w_adj_res[4*i +: 4] = w_adj_v[3:0];
        end
        w_adj_c = (r_op == OP_SBC) ? r_nc[NIB-1] : w_adj_dc;
    end

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_shift && (I_count != '0)) w_state_next = S_BUSY;
                    else if (w_dec)                     w_state_next = S_ADJUST;
                    else                                w_state_next = S_DONE;
                end
            end
            S_BUSY:   if (r_cnt == CNT_ONE) w_state_next = S_DONE;
            S_ADJUST: w_state_next = S_DONE;
            S_DONE:   if (r_valid && I_accept) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            r_valid  <= 1'b0;
            r_op     <= OP_NOP;
            r_cnt    <= '0;
            r_nc     <= '0;
            r_result <= '0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= I_control;
                        r_cnt    <= I_count;
                        r_nc     <= w_nc;
                        r_result <= w_res;
                        r_c      <= w_c;
                        r_v      <= w_v;
                        r_n      <= w_n;
                        r_z      <= w_z;
                    end
                end
                S_BUSY: begin
                    r_result <= w_st_res;
                    r_c      <= w_st_c;
                    r_n      <= w_st_res[MSB];
                    r_z      <= (w_st_res == '0);
                    r_cnt    <= r_cnt - CNT_ONE;
                    r_valid  <= (r_cnt == CNT_ONE);
                end
                S_ADJUST: begin
                    r_result <= w_adj_res;
                    r_c      <= w_adj_c;
                end
                S_DONE: begin
                    if (!r_valid)      r_valid <= 1'b1;
                    else if (I_accept) r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_core_alu_seq.sv
// Bench for core_alu_seq: 8-bit BCD-capable instance plus a 16-bit binary instance.
module tb_core_alu_seq;
    localparam logic [3:0] OP_NOP = 4'd0, OP_ADC = 4'd1, OP_SBC = 4'd2, OP_CMP = 4'd3;
    localparam logic [3:0] OP_INC = 4'd4, OP_DEC = 4'd5, OP_BIT = 4'd7, OP_XOR = 4'd9;
    localparam logic [3:0] OP_ASL = 4'd10, OP_LSR = 4'd11, OP_ROL = 4'd12, OP_ROR = 4'd13;
    localparam logic [3:0] OP_TXR = 4'd15;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flg;
        logic [7:0] lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, a_ready, a_accept = 1'b0, a_ovalid;
    logic [3:0] a_ctrl = 4'd0;
    logic [7:0] a_lhs = 8'd0, a_rhs = 8'd0, a_res;
    logic [2:0] a_cnt = 3'd0;
    logic       a_c = 1'b0, a_v = 1'b0, a_n = 1'b0, a_z = 1'b0, a_d = 1'b0;
    logic       a_oc, a_ov, a_on, a_oz;

    logic        b_valid = 1'b0, b_ready, b_accept = 1'b0, b_ovalid;
    logic [3:0]  b_ctrl = 4'd0;
    logic [15:0] b_lhs = 16'd0, b_rhs = 16'd0, b_res;
    logic [2:0]  b_cnt = 3'd0;
    logic        b_oc, b_ov, b_on, b_oz;

    always #5 clk = ~clk;

    core_alu_seq #(.WIDTH(8), .DECIMAL(1), .COUNT_BITS(3)) dut (
        .I_clock(clk), .I_reset(rst), .I_valid(a_valid), .O_ready(a_ready),
        .I_control(a_ctrl), .I_lhs(a_lhs), .I_rhs(a_rhs), .I_count(a_cnt),
        .I_carry(a_c), .I_overflow(a_v), .I_sign(a_n), .I_zero(a_z), .I_decimal(a_d),
        .O_valid(a_ovalid), .I_accept(a_accept), .O_result(a_res),
        .O_carry(a_oc), .O_overflow(a_ov), .O_sign(a_on), .O_zero(a_oz)
    );

    core_alu_seq #(.WIDTH(16), .DECIMAL(0), .COUNT_BITS(3)) dut16 (
        .I_clock(clk), .I_reset(rst), .I_valid(b_valid), .O_ready(b_ready),
        .I_control(b_ctrl), .I_lhs(b_lhs), .I_rhs(b_rhs), .I_count(b_cnt),
        .I_carry(1'b0), .I_overflow(1'b0), .I_sign(1'b0), .I_zero(1'b0), .I_decimal(1'b0),
        .O_valid(b_ovalid), .I_accept(b_accept), .O_result(b_res),
        .O_carry(b_oc), .O_overflow(b_ov), .O_sign(b_on), .O_zero(b_oz)
    );

    // fin = {C,V,N,Z,D} in; eflg = {C,V,N,Z} out. Inputs are scrambled after accept.
    task automatic run_op(input string name, input logic [3:0] op, input logic [7:0] lhs,
                          input logic [7:0] rhs, input logic [2:0] cnt, input logic [4:0] fin,
                          input logic [7:0] eres, input logic [3:0] eflg, input int elat,
                          input int hold);
        exp_t       e;
        int         lat;
        int         waitc;
        logic [7:0] held;
        waitc = 0;
        @(negedge clk);
        while (!a_ready && waitc < 50) begin @(negedge clk); waitc++; end
        a_ctrl = op; a_lhs = lhs; a_rhs = rhs; a_cnt = cnt;
        {a_c, a_v, a_n, a_z, a_d} = fin;
        a_valid = 1'b1;
        exp_q.push_back('{res: eres, flg: eflg, lat: 8'(elat)});
        @(posedge clk); #1;
        a_valid = 1'b0; a_ctrl = ~op; a_lhs = ~lhs; a_rhs = ~rhs; a_cnt = ~cnt;
        {a_c, a_v, a_n, a_z, a_d} = ~fin;
        n_checks++;
        if (a_ready !== 1'b0) begin
            n_err++; $display("FAIL %s accept: ready=%b required 0", name, a_ready);
        end
        lat = 0;
        while (a_ovalid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== int'(e.lat)) begin
            n_err++; $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
        end
        n_checks++;
        if (a_res !== e.res) begin
            n_err++; $display("FAIL %s result: got %h required %h", name, a_res, e.res);
        end
        n_checks++;
        if ({a_oc, a_ov, a_on, a_oz} !== e.flg) begin
            n_err++; $display("FAIL %s flags CVNZ: got %b required %b", name,
                              {a_oc, a_ov, a_on, a_oz}, e.flg);
        end
        if (hold > 0) begin
            held = a_res;
            repeat (hold) @(posedge clk);
            #1;
            n_checks++;
            if (a_ovalid !== 1'b1 || a_res !== held || a_ready !== 1'b0) begin
                n_err++; $display("FAIL %s hold: valid=%b ready=%b res=%h required 1 0 %h",
                                  name, a_ovalid, a_ready, a_res, held);
            end
        end
        @(negedge clk); a_accept = 1'b1;
        @(posedge clk); #1; a_accept = 1'b0;
        n_checks++;
        if (a_ovalid !== 1'b0 || a_ready !== 1'b1) begin
            n_err++; $display("FAIL %s release: valid=%b ready=%b required 0 1",
                              name, a_ovalid, a_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({a_ready, a_ovalid, a_res, a_oc, a_ov, a_on, a_oz} !== {1'b1, 1'b0, 8'h00, 4'b0000}) begin
            n_err++; $display("FAIL reset_state: rdy=%b vld=%b res=%h cvnz=%b required 1 0 00 0000",
                              a_ready, a_ovalid, a_res, {a_oc, a_ov, a_on, a_oz});
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({a_ready, a_ovalid, a_res, a_oc, a_ov, a_on, a_oz} !== {1'b1, 1'b0, 8'h00, 4'b0000}) begin
            n_err++; $display("FAIL idle_state: rdy=%b vld=%b res=%h cvnz=%b required 1 0 00 0000",
                              a_ready, a_ovalid, a_res, {a_oc, a_ov, a_on, a_oz});
        end
    endtask

    task automatic test_arith();
        run_op("adc_5050", OP_ADC, 8'h50, 8'h50, 3'd0, 5'b00000, 8'hA0, 4'b0110, 1, 5);
        run_op("sbc_0001", OP_SBC, 8'h00, 8'h01, 3'd0, 5'b10000, 8'hFF, 4'b0010, 1, 0);
        run_op("cmp_4040", OP_CMP, 8'h40, 8'h40, 3'd0, 5'b01000, 8'h40, 4'b1101, 1, 0);
        run_op("inc_ff",   OP_INC, 8'hFF, 8'h00, 3'd0, 5'b10000, 8'h00, 4'b1001, 1, 0);
        run_op("dec_00",   OP_DEC, 8'h00, 8'h00, 3'd0, 5'b00000, 8'hFF, 4'b0010, 1, 0);
    endtask

    task automatic test_logic();
        run_op("bit_0fc0", OP_BIT, 8'h0F, 8'hC0, 3'd0, 5'b10000, 8'h0F, 4'b1111, 1, 0);
        run_op("xor_f0ff", OP_XOR, 8'hF0, 8'hFF, 3'd0, 5'b11000, 8'h0F, 4'b1100, 1, 0);
        run_op("nop_pass", OP_NOP, 8'h00, 8'h33, 3'd0, 5'b01100, 8'h00, 4'b0110, 1, 0);
        run_op("txr_80",   OP_TXR, 8'h12, 8'h80, 3'd0, 5'b00000, 8'h80, 4'b0010, 1, 0);
    endtask

    task automatic test_shifts();
        run_op("rol_81x3", OP_ROL, 8'h81, 8'h00, 3'd3, 5'b10000, 8'h0E, 4'b0000, 3, 0);
        run_op("lsr_01x0", OP_LSR, 8'h01, 8'h00, 3'd0, 5'b10000, 8'h01, 4'b1000, 1, 0);
        run_op("asl_01x7", OP_ASL, 8'h01, 8'h00, 3'd7, 5'b00000, 8'h80, 4'b0010, 7, 0);
        run_op("ror_01x2", OP_ROR, 8'h01, 8'h00, 3'd2, 5'b00000, 8'h80, 4'b0010, 2, 0);
        run_op("lsr_03x1", OP_LSR, 8'h03, 8'h00, 3'd1, 5'b00000, 8'h01, 4'b1000, 1, 0);
    endtask

    task automatic test_decimal();
        run_op("dadc_1928", OP_ADC, 8'h19, 8'h28, 3'd0, 5'b00001, 8'h47, 4'b0000, 2, 0);
        run_op("dadc_9901", OP_ADC, 8'h99, 8'h01, 3'd0, 5'b00001, 8'h00, 4'b1010, 2, 0);
        run_op("dsbc_1001", OP_SBC, 8'h10, 8'h01, 3'd0, 5'b10001, 8'h09, 4'b1000, 2, 0);
    endtask

    task automatic test_reset_midshift();
        int waitc;
        int seen;
        waitc = 0;
        @(negedge clk);
        while (!a_ready && waitc < 50) begin @(negedge clk); waitc++; end
        a_ctrl = OP_ROL; a_lhs = 8'h81; a_cnt = 3'd7; {a_c, a_v, a_n, a_z, a_d} = 5'b10000;
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst = 1'b1; a_valid = 1'b1; #1;
        n_checks++;
        if (a_ready !== 1'b1 || a_ovalid !== 1'b0) begin
            n_err++; $display("FAIL reset_abort: ready=%b valid=%b required 1 0", a_ready, a_ovalid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); a_valid = 1'b0; rst = 1'b0;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (a_ovalid) seen++; end
        n_checks++;
        if (seen !== 0 || a_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_no_valid: valid_cycles=%0d ready=%b required 0 1", seen, a_ready);
        end
    endtask

    task automatic test_wide();
        int lat;
        @(negedge clk);
        b_ctrl = OP_ADC; b_lhs = 16'h7FFF; b_rhs = 16'h0001; b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0; b_lhs = 16'h0000; b_rhs = 16'h0000;
        lat = 0;
        while (b_ovalid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (lat !== 1 || b_res !== 16'h8000) begin
            n_err++; $display("FAIL wide_adc: lat=%0d res=%h required 1 8000", lat, b_res);
        end
        n_checks++;
        if ({b_oc, b_ov, b_on, b_oz} !== 4'b0110) begin
            n_err++; $display("FAIL wide_flags CVNZ: got %b required 0110", {b_oc, b_ov, b_on, b_oz});
        end
        @(negedge clk); b_accept = 1'b1;
        @(posedge clk); #1; b_accept = 1'b0;
        n_checks++;
        if (b_ready !== 1'b1 || b_ovalid !== 1'b0) begin
            n_err++; $display("FAIL wide_release: ready=%b valid=%b required 1 0", b_ready, b_ovalid);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_shifts();
        test_decimal();
        test_reset_midshift();
        test_arith();
        test_wide();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
